// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing issue path: DP opcodes,
// barrel-shifter type codes and the issue FSM encoding.
package dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {IDLE, RS, OPS, OUT} dp_state_e;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
        ror32 = (r == 5'd0) ? v : ((v >> r) | (v << (6'd32 - {1'b0, r})));
    endfunction

endpackage

// File: rtl/dp_barrel_shifter.sv
// Combinational ARM barrel shifter covering immediate-rotate, immediate-shift
// and register-shift forms; also used by the load/store offset path.
module dp_barrel_shifter
    import dp_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  amount,
    input  logic        reg_form,
    input  logic        imm_form,
    input  logic        c_in,
    output logic [31:0] result,
    output logic        carry
);

    logic [32:0] t;
    logic [7:0]  n;

    always_comb begin
        result = value;
        carry  = c_in;
        t      = '0;
        n      = amount;
        if (imm_form) begin
            result = ror32(value, amount[4:0]);
            carry  = (amount == 8'd0) ? c_in : result[31];
        end else if (amount == 8'd0 && (reg_form || shift_type == SH_LSL)) begin
            result = value;
            carry  = c_in;
        end else if (amount == 8'd0 && shift_type == SH_ROR) begin
            result = {c_in, value[31:1]};
            carry  = value[0];
        end else begin
            // Immediate LSR/ASR #0 encode a shift by 32.
            n = (amount == 8'd0) ? 8'd32 : amount;
            case (shift_type)
                SH_LSL: begin
                    if (n > 8'd32) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        t      = {1'b0, value} << n;
                        result = t[31:0];
                        carry  = t[32];
                    end
                end
                SH_LSR: begin
                    if (n > 8'd32) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        t      = {value, 1'b0} >> n;
                        result = t[32:1];
                        carry  = t[0];
                    end
                end
                SH_ASR: begin
                    if (n >= 8'd32) begin
                        result = {32{value[31]}};
                        carry  = value[31];
                    end else begin
                        t      = 33'($signed({value, 1'b0}) >>> n);
                        result = t[32:1];
                        carry  = t[0];
                    end
                end
                default: begin
                    result = ror32(value, n[4:0]);
                    carry  = result[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/dp_operand_issue.sv
// Issue stage for DP instructions: reads Rn/Rm/Rs, runs the shifter and hands
// registered operands to the ALU. DP_OPERAND_ISSUE_FWD_EN adds writeback forwarding.
module dp_operand_issue
    import dp_pkg::*;
#(
    parameter int          RF_AW  = 4,
    parameter logic [31:0] PC_OFS = 32'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             cpsr_c,
    output logic [RF_AW-1:0] rf_raddr0,
    input  logic [31:0]      rf_rdata0,
    output logic [RF_AW-1:0] rf_raddr1,
    input  logic [31:0]      rf_rdata1,
`ifdef DP_OPERAND_ISSUE_FWD_EN
    input  logic             wb_en,
    input  logic [RF_AW-1:0] wb_addr,
    input  logic [31:0]      wb_data,
`endif
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [3:0]       alu_opcode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_shc,
    output logic             alu_s,
    output logic [3:0]       alu_rd
);

    localparam logic [RF_AW-1:0] R15 = '1;

    dp_state_e   state_q, state_d;
    logic [25:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  shamt_q, shamt_d;
    logic [3:0]  op_q, op_d, rd_q, rd_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        shc_q, shc_d, s_q, s_d;

    logic        accept, reg_form;
    logic [31:0] r15_val, rd0_val, rd1_val, sh_value, sh_result;
    logic [7:0]  sh_amount;
    logic        sh_carry;
    logic        unused_cond;

    assign unused_cond = ^in_instr[31:26];

    assign in_ready  = !flush && (state_q == IDLE || (state_q == OUT && alu_ready));
    assign accept    = in_valid && in_ready;
    assign reg_form  = !instr_q[25] && instr_q[4];
    assign r15_val   = pc_q + PC_OFS + (reg_form ? 32'd4 : 32'd0);
    assign rf_raddr0 = instr_q[19:16];
    assign rf_raddr1 = (state_q == RS) ? instr_q[11:8] : instr_q[3:0];

    // R15 always comes from the latched PC, ahead of any forwarded value.
    always_comb begin
        rd0_val = rf_rdata0;
        rd1_val = rf_rdata1;
`ifdef DP_OPERAND_ISSUE_FWD_EN
        if (wb_en && wb_addr == rf_raddr0) rd0_val = wb_data;
        if (wb_en && wb_addr == rf_raddr1) rd1_val = wb_data;
`endif
        if (rf_raddr0 == R15) rd0_val = r15_val;
        if (rf_raddr1 == R15) rd1_val = r15_val;
    end

    assign sh_value  = instr_q[25] ? {24'd0, instr_q[7:0]} : rd1_val;
    assign sh_amount = instr_q[25] ? {3'd0, instr_q[11:8], 1'b0}
                     : (reg_form ? shamt_q : {3'd0, instr_q[11:7]});

    dp_barrel_shifter u_shifter (
        .value      (sh_value),
        .shift_type (instr_q[6:5]),
        .amount     (sh_amount),
        .reg_form   (reg_form),
        .imm_form   (instr_q[25]),
        .c_in       (cpsr_c),
        .result     (sh_result),
        .carry      (sh_carry)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        shc_d   = shc_q;
        s_d     = s_q;
        rd_d    = rd_q;
        if (accept) begin
            instr_d = in_instr[25:0];
            pc_d    = in_pc;
        end
        case (state_q)
            IDLE: if (accept) state_d = (!in_instr[25] && in_instr[4]) ? RS : OPS;
            RS: begin
                shamt_d = rd1_val[7:0];
                state_d = OPS;
            end
            OPS: begin
                op_d    = instr_q[24:21];
                s_d     = instr_q[20];
                rd_d    = instr_q[15:12];
                a_d     = rd0_val;
                b_d     = sh_result;
                shc_d   = sh_carry;
                state_d = OUT;
            end
            default: begin
                if (alu_ready) begin
                    if (accept) state_d = (!in_instr[25] && in_instr[4]) ? RS : OPS;
                    else        state_d = IDLE;
                end
            end
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shc_q   <= 1'b0;
            s_q     <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shc_q   <= shc_d;
            s_q     <= s_d;
            rd_q    <= rd_d;
        end
    end

    assign alu_valid  = (state_q == OUT);
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_shc    = shc_q;
    assign alu_s      = s_q;
    assign alu_rd     = rd_q;

endmodule

// File: tb/tb_dp_operand_issue.sv
// Directed bench for dp_operand_issue: expected ALU operands are queued at
// issue time and compared by a monitor when the ALU handshake completes.
module tb_dp_operand_issue;
    import dp_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic        in_ready, cpsr_c = 1'b0, alu_ready = 1'b1, alu_valid;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [3:0]  rf_raddr0, rf_raddr1, alu_opcode, alu_rd;
    logic [31:0] rf_rdata0, rf_rdata1, alu_a, alu_b;
    logic        alu_shc, alu_s;
    logic [31:0] rf [16];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        shc, s;
        logic [3:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;

    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];

    always #5 clk = ~clk;

    dp_operand_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .cpsr_c(cpsr_c),
        .rf_raddr0(rf_raddr0), .rf_rdata0(rf_rdata0),
        .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
`ifdef DP_OPERAND_ISSUE_FWD_EN
        .wb_en(1'b0), .wb_addr(4'd0), .wb_data(32'd0),
`endif
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shc(alu_shc), .alu_s(alu_s), .alu_rd(alu_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic shc, input logic s, input logic [3:0] rd);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.shc = shc; e.s = s; e.rd = rd;
        return e;
    endfunction

    function automatic logic [31:0] enc_imm(input logic [3:0] op, input logic s, input logic [3:0] rn,
                                            input logic [3:0] rd, input logic [3:0] rot, input logic [7:0] imm);
        return {4'hE, 2'b00, 1'b1, op, s, rn, rd, rot, imm};
    endfunction

    function automatic logic [31:0] enc_rsi(input logic [3:0] op, input logic s, input logic [3:0] rn,
                                            input logic [3:0] rd, input logic [4:0] sh, input logic [1:0] ty,
                                            input logic [3:0] rm);
        return {4'hE, 2'b00, 1'b0, op, s, rn, rd, sh, ty, 1'b0, rm};
    endfunction

    function automatic logic [31:0] enc_rsr(input logic [3:0] op, input logic s, input logic [3:0] rn,
                                            input logic [3:0] rd, input logic [3:0] rs, input logic [1:0] ty,
                                            input logic [3:0] rm);
        return {4'hE, 2'b00, 1'b0, op, s, rn, rd, rs, 1'b0, ty, 1'b1, rm};
    endfunction

    always @(negedge clk) begin
        if (rst_n && alu_valid && alu_ready) begin
            if (sb.size() == 0) begin
                chk("no_stale_issue", {31'd0, alu_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, e.op});
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_shc", {31'd0, alu_shc}, {31'd0, e.shc});
                chk("alu_s", {31'd0, alu_s}, {31'd0, e.s});
                chk("alu_rd", {28'd0, alu_rd}, {28'd0, e.rd});
            end
        end
    end

    // Drives one instruction and returns just after its accepting edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input bit push, input exp_t e);
        int k;
        @(posedge clk); #1;
        in_instr = instr; in_pc = pc; in_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_and_drain(input int exp_lat);
        int lat, k;
        lat = 1;
        @(negedge clk);
        while (!alu_valid && lat < 10) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        k = 0;
        while (sb.size() != 0 && k < 10) begin @(negedge clk); k++; end
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic run(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, input int exp_lat);
        issue(instr, pc, 1'b1, e);
        lat_and_drain(exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t ea, eb, dummy;
        int   k;
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[0] = 32'h11;        rf[2] = 32'h2222;      rf[3] = 32'h8000_0001;
        rf[5] = 32'h3;         rf[7] = 32'h1;         rf[9] = 32'hF8;
        rf[10] = 32'h8000_0000; rf[11] = 32'h8000_0001; rf[12] = 32'h7FFF_FFFF;
        rf[13] = 32'h1234_5678; rf[15] = 32'hDEAD_BEEF;
        dummy = mk(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);

        #1;
        chk("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        #20 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Immediate forms
        cpsr_c = 1'b0;
        run(enc_imm(OP_MOV, 1'b0, 4'd0, 4'd0, 4'd4, 8'hFF), 32'h0,
            mk(OP_MOV, 32'h11, 32'hFF00_0000, 1'b1, 1'b0, 4'd0), 2);
        cpsr_c = 1'b1;
        run(enc_imm(OP_MOV, 1'b0, 4'd0, 4'd1, 4'd0, 8'h5A), 32'h0,
            mk(OP_MOV, 32'h11, 32'h5A, 1'b1, 1'b0, 4'd1), 2);
        run(enc_imm(OP_MOV, 1'b0, 4'd0, 4'd1, 4'd1, 8'h01), 32'h0,
            mk(OP_MOV, 32'h11, 32'h4000_0000, 1'b0, 1'b0, 4'd1), 2);

        // Immediate shift amounts
        cpsr_c = 1'b0;
        run(enc_rsi(OP_ADD, 1'b0, 4'd2, 4'd1, 5'd0, SH_LSR, 4'd3), 32'h0,
            mk(OP_ADD, 32'h2222, 32'h0, 1'b1, 1'b0, 4'd1), 2);
        cpsr_c = 1'b1;
        run(enc_rsi(OP_MOV, 1'b1, 4'd0, 4'd4, 5'd0, SH_ROR, 4'd5), 32'h0,
            mk(OP_MOV, 32'h11, 32'h8000_0001, 1'b1, 1'b1, 4'd4), 2);
        cpsr_c = 1'b0;
        run(enc_rsi(OP_MOV, 1'b0, 4'd0, 4'd9, 5'd0, SH_ASR, 4'd10), 32'h0,
            mk(OP_MOV, 32'h11, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd9), 2);
        run(enc_rsi(OP_MOV, 1'b0, 4'd0, 4'd2, 5'd1, SH_LSL, 4'd11), 32'h0,
            mk(OP_MOV, 32'h11, 32'h2, 1'b1, 1'b0, 4'd2), 2);
        run(enc_rsi(OP_SUB, 1'b1, 4'd2, 4'd3, 5'd4, SH_LSR, 4'd9), 32'h0,
            mk(OP_SUB, 32'h2222, 32'hF, 1'b1, 1'b1, 4'd3), 2);
        cpsr_c = 1'b1;
        run(enc_rsi(OP_ADD, 1'b0, 4'd15, 4'd2, 5'd0, SH_LSL, 4'd15), 32'h200,
            mk(OP_ADD, 32'h208, 32'h208, 1'b1, 1'b0, 4'd2), 2);

        // Register-specified shifts
        cpsr_c = 1'b0; rf[8] = 32'h100;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd6, 4'd8, SH_LSL, 4'd7), 32'h0,
            mk(OP_MOV, 32'h11, 32'h1, 1'b0, 1'b0, 4'd6), 3);
        rf[8] = 32'd32;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd6, 4'd8, SH_LSL, 4'd7), 32'h0,
            mk(OP_MOV, 32'h11, 32'h0, 1'b1, 1'b0, 4'd6), 3);
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd0, 4'd8, SH_LSR, 4'd10), 32'h0,
            mk(OP_MOV, 32'h11, 32'h0, 1'b1, 1'b0, 4'd0), 3);
        cpsr_c = 1'b1; rf[8] = 32'd33;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd6, 4'd8, SH_LSL, 4'd7), 32'h0,
            mk(OP_MOV, 32'h11, 32'h0, 1'b0, 1'b0, 4'd6), 3);
        cpsr_c = 1'b0;
        run(enc_rsr(OP_ADD, 1'b0, 4'd15, 4'd0, 4'd1, SH_LSL, 4'd15), 32'h100,
            mk(OP_ADD, 32'h10C, 32'h10C, 1'b0, 1'b0, 4'd0), 3);
        rf[14] = 32'd4;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd12, 4'd14, SH_ROR, 4'd13), 32'h0,
            mk(OP_MOV, 32'h11, 32'h8123_4567, 1'b1, 1'b0, 4'd12), 3);
        cpsr_c = 1'b1; rf[14] = 32'd32;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd12, 4'd14, SH_ROR, 4'd13), 32'h0,
            mk(OP_MOV, 32'h11, 32'h1234_5678, 1'b0, 1'b0, 4'd12), 3);
        rf[14] = 32'd40;
        run(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd1, 4'd14, SH_ASR, 4'd12), 32'h0,
            mk(OP_MOV, 32'h11, 32'h0, 1'b0, 1'b0, 4'd1), 3);

        // Flush while in RS, with a competing in_valid that must not be taken
        rf[8] = 32'd1;
        issue(enc_rsr(OP_MOV, 1'b0, 4'd0, 4'd6, 4'd8, SH_LSL, 4'd7), 32'h0, 1'b0, dummy);
        flush = 1'b1; in_valid = 1'b1;
        in_instr = enc_imm(OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 8'h77);
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_valid", {31'd0, alu_valid}, 32'd0);
        end

        // ALU stall for 5 cycles, then release together with a new instruction
        cpsr_c = 1'b0; alu_ready = 1'b0;
        ea = mk(OP_SUB, 32'h2222, 32'h1, 1'b0, 1'b1, 4'd3);
        eb = mk(OP_ORR, 32'h2222, 32'h8000_0001, 1'b0, 1'b0, 4'd5);
        issue(enc_imm(OP_SUB, 1'b1, 4'd2, 4'd3, 4'd0, 8'h01), 32'h0, 1'b1, ea);
        k = 0;
        while (!alu_valid && k < 10) begin @(negedge clk); k++; end
        chk("stall_valid", {31'd0, alu_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", {31'd0, alu_valid}, 32'd1);
            chk("stall_hold_a", alu_a, ea.a);
            chk("stall_hold_b", alu_b, ea.b);
            chk("stall_hold_s", {31'd0, alu_s}, {31'd0, ea.s});
        end
        @(posedge clk); #1;
        alu_ready = 1'b1; in_valid = 1'b1;
        in_instr = enc_rsi(OP_ORR, 1'b0, 4'd2, 4'd5, 5'd0, SH_LSL, 4'd3);
        sb.push_back(eb);
        @(negedge clk);
        chk("pulse_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat_and_drain(2);

        // Async reset while in OPS: instruction is discarded
        issue(enc_imm(OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 8'h12), 32'h0, 1'b0, dummy);
        rst_n = 1'b0; #1;
        chk("rst_ops_valid", {31'd0, alu_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ops_discard", {31'd0, alu_valid}, 32'd0);
        end

        // Async reset while alu_valid is high drops it immediately
        issue(enc_imm(OP_MOV, 1'b0, 4'd0, 4'd0, 4'd0, 8'h34), 32'h0, 1'b0, dummy);
        @(posedge clk); #1;
        chk("out_before_rst", {31'd0, alu_valid}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_out_valid", {31'd0, alu_valid}, 32'd0);
        chk("rst_out_b", alu_b, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
